// File: rtl/rgb2hsv_if.sv
// Pixel stream bundle for rgb2hsv: RGB888 + syncs in, fixed-point HSV + delayed syncs out.
// The master drives the pixels. The slave is the converter.
interface rgb2hsv_if;
  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;
  logic       vs;
  logic       hs;
  logic       de;
  logic [8:0] o_hsv_h;
  logic [8:0] o_hsv_s;
  logic [7:0] o_hsv_v;
  logic       hsv_vs;
  logic       hsv_hs;
  logic       hsv_de;

  modport master (
    output rgb_r, rgb_g, rgb_b, vs, hs, de,
    input  o_hsv_h, o_hsv_s, o_hsv_v, hsv_vs, hsv_hs, hsv_de
  );

  modport slave (
    input  rgb_r, rgb_g, rgb_b, vs, hs, de,
    output o_hsv_h, o_hsv_s, o_hsv_v, hsv_vs, hsv_hs, hsv_de
  );
endinterface

// File: rtl/rgb2hsv.sv
// rgb2hsv: 5-stage RGB888 -> HSV (H 0..359, S 0..256, V 0..255), syncs delayed in lockstep.
// Optional macro RGB2HSV_DE_GATE_EN forces H/S/V to 0 whenever the delayed de is low.
module rgb2hsv (
  input logic      clk,
  input logic      reset,
  rgb2hsv_if.slave bus
);
  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

  logic [4:0][2:0] sync_sr;

  logic [7:0]  r1, g1, b1;
  logic [7:0]  max1, min1, diff1;
  sector_t     sec1;
  logic        neg1;

  logic [7:0]  delta2, max2;
  logic [13:0] hnum2;
  logic [15:0] snum2;
  sector_t     sec2;
  logic        neg2;

  logic [7:0]  hdiv, sdiv;
  logic [5:0]  hq;
  logic [8:0]  sq;

  logic [5:0]  q3;
  logic [8:0]  s3;
  logic [7:0]  v3;
  sector_t     sec3;
  logic        neg3, flat3;

  logic [8:0]  h_calc;
  logic [8:0]  h4, s4;
  logic [7:0]  v4;

  logic        keep;
  logic [8:0]  h5, s5;
  logic [7:0]  v5;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_sr <= '0;
    else       sync_sr <= {sync_sr[3:0], {bus.vs, bus.hs, bus.de}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1 <= '0;
      g1 <= '0;
      b1 <= '0;
    end else begin
      r1 <= bus.rgb_r;
      g1 <= bus.rgb_g;
      b1 <= bus.rgb_b;
    end
  end

  // Sector picks the max component with tie priority r > g > b.
  always_comb begin
    sec1  = SEC_B;
    neg1  = 1'b0;
    diff1 = 8'd0;
    if (r1 >= g1 && r1 >= b1) sec1 = SEC_R;
    else if (g1 >= b1)        sec1 = SEC_G;
    min1 = (r1 <= g1 && r1 <= b1) ? r1 : ((g1 <= b1) ? g1 : b1);
    case (sec1)
      SEC_R: begin
        max1 = r1;
        if (g1 >= b1) diff1 = g1 - b1;
        else begin diff1 = b1 - g1; neg1 = 1'b1; end
      end
      SEC_G: begin
        max1 = g1;
        if (b1 >= r1) diff1 = b1 - r1;
        else begin diff1 = r1 - b1; neg1 = 1'b1; end
      end
      default: begin
        max1 = b1;
        if (r1 >= g1) diff1 = r1 - g1;
        else begin diff1 = g1 - r1; neg1 = 1'b1; end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delta2 <= '0;
      max2   <= '0;
      hnum2  <= '0;
      snum2  <= '0;
      sec2   <= SEC_R;
      neg2   <= 1'b0;
    end else begin
      delta2 <= max1 - min1;
      max2   <= max1;
      hnum2  <= {6'd0, diff1} * 14'd60;
      snum2  <= {max1 - min1, 8'h00};
      sec2   <= sec1;
      neg2   <= neg1;
    end
  end

  // Divisors are never zero; the degenerate cases are overridden on registration.
  assign hdiv = (delta2 == 8'd0) ? 8'd1 : delta2;
  assign sdiv = (max2 == 8'd0) ? 8'd1 : max2;
  assign hq   = 6'(hnum2 / {6'd0, hdiv});
  assign sq   = 9'(snum2 / {8'd0, sdiv});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q3    <= '0;
      s3    <= '0;
      v3    <= '0;
      sec3  <= SEC_R;
      neg3  <= 1'b0;
      flat3 <= 1'b0;
    end else begin
      q3    <= (delta2 == 8'd0) ? 6'd0 : hq;
      s3    <= (max2 == 8'd0) ? 9'd0 : sq;
      v3    <= max2;
      sec3  <= sec2;
      neg3  <= neg2;
      flat3 <= (delta2 == 8'd0);
    end
  end

  // 360 degrees is reported as 0 so H always stays within 0..359.
  always_comb begin
    h_calc = 9'd0;
    if (!flat3) begin
      case (sec3)
        SEC_R:   h_calc = (neg3 && q3 != 6'd0) ? 9'd360 - {3'd0, q3} : (neg3 ? 9'd0 : {3'd0, q3});
        SEC_G:   h_calc = neg3 ? 9'd120 - {3'd0, q3} : 9'd120 + {3'd0, q3};
        default: h_calc = neg3 ? 9'd240 - {3'd0, q3} : 9'd240 + {3'd0, q3};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h4 <= '0;
      s4 <= '0;
      v4 <= '0;
    end else begin
      h4 <= h_calc;
      s4 <= s3;
      v4 <= v3;
    end
  end

`ifdef RGB2HSV_DE_GATE_EN
  assign keep = sync_sr[3][0];
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h5 <= '0;
      s5 <= '0;
      v5 <= '0;
    end else begin
      h5 <= keep ? h4 : 9'd0;
      s5 <= keep ? s4 : 9'd0;
      v5 <= keep ? v4 : 8'd0;
    end
  end

  assign bus.o_hsv_h = h5;
  assign bus.o_hsv_s = s5;
  assign bus.o_hsv_v = v5;
  assign bus.hsv_vs  = sync_sr[4][2];
  assign bus.hsv_hs  = sync_sr[4][1];
  assign bus.hsv_de  = sync_sr[4][0];
endmodule

// File: tb/tb_rgb2hsv.sv
// Scoreboard bench for rgb2hsv: expected HSV/sync words queued on every sampled input.
module tb_rgb2hsv;
  typedef struct packed {
    logic [8:0] h;
    logic [8:0] s;
    logic [7:0] v;
    logic       vs;
    logic       hs;
    logic       de;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  rgb2hsv_if bus ();
  rgb2hsv dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] r, g, b, input logic v_s, h_s, d_e);
    int ri = r;
    int gi = g;
    int bi = b;
    int mx, mn, d, h, s;
    exp_t m;
    mx = (ri > gi) ? ri : gi;
    mx = (mx > bi) ? mx : bi;
    mn = (ri < gi) ? ri : gi;
    mn = (mn < bi) ? mn : bi;
    d  = mx - mn;
    s  = (mx == 0) ? 0 : (d * 256) / mx;
    if (d == 0)       h = 0;
    else if (ri == mx) h = (gi >= bi) ? (60 * (gi - bi)) / d : 360 - (60 * (bi - gi)) / d;
    else if (gi == mx) h = (bi >= ri) ? 120 + (60 * (bi - ri)) / d : 120 - (60 * (ri - bi)) / d;
    else               h = (ri >= gi) ? 240 + (60 * (ri - gi)) / d : 240 - (60 * (gi - ri)) / d;
    if (h == 360) h = 0;
`ifdef RGB2HSV_DE_GATE_EN
    if (!d_e) begin h = 0; s = 0; mx = 0; end
`endif
    m.h = 9'(h);
    m.s = 9'(s);
    m.v = 8'(mx);
    m.vs = v_s;
    m.hs = h_s;
    m.de = d_e;
    return m;
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("h=%0d s=%0d v=%0d vs=%b hs=%b de=%b", x.h, x.s, x.v, x.vs, x.hs, x.de);
  endfunction

  function automatic exp_t observed();
    return {bus.o_hsv_h, bus.o_hsv_s, bus.o_hsv_v, bus.hsv_vs, bus.hsv_hs, bus.hsv_de};
  endfunction

  // One pixel per clock: drive, let the DUT sample, queue its expectation, pop the one now due.
  task automatic cycle(input logic [7:0] r, g, b, input logic v_s, h_s, d_e,
                       output exp_t e, output exp_t o);
    bus.rgb_r = r;
    bus.rgb_g = g;
    bus.rgb_b = b;
    bus.vs = v_s;
    bus.hs = h_s;
    bus.de = d_e;
    @(posedge clk);
    sb.push_back(model(r, g, b, v_s, h_s, d_e));
    #1;
    e = sb.pop_front();
    o = observed();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    sb.delete();
    repeat (4) sb.push_back('0);
  endtask

  task automatic test_reset();
    exp_t o;
    bus.rgb_r = 8'd200; bus.rgb_g = 8'd10; bus.rgb_b = 8'd30;
    bus.vs = 1'b1; bus.hs = 1'b1; bus.de = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      o = observed();
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_hold: got %s want all zero", fmt(o)); end
    end
    release_reset();
  endtask

  task automatic test_primaries();
    logic [23:0] px [3];
    exp_t want [3];
    exp_t e, o;
    px = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
    want = '{'{9'd0, 9'd256, 8'd255, 1'b0, 1'b0, 1'b1},
             '{9'd120, 9'd256, 8'd255, 1'b0, 1'b0, 1'b1},
             '{9'd240, 9'd256, 8'd255, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      if (i < 3) cycle(px[i][23:16], px[i][15:8], px[i][7:0], 1'b0, 1'b0, 1'b1, e, o);
      else       cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL primaries[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      n_checks++;
      if (o.h >= 9'd360) begin n_fail++; $display("FAIL primaries_hrange: got h=%0d want <360", o.h); end
      if (i >= 4) begin
        n_checks++;
        if (o !== want[i-4]) begin n_fail++; $display("FAIL primaries_const[%0d]: got %s want %s", i-4, fmt(o), fmt(want[i-4])); end
      end
    end
  endtask

  task automatic test_gray_black();
    logic [23:0] px [2];
    exp_t want [2];
    exp_t e, o;
    px = '{24'h808080, 24'h000000};
    want = '{'{9'd0, 9'd0, 8'd128, 1'b0, 1'b0, 1'b1},
             '{9'd0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      if (i < 2) cycle(px[i][23:16], px[i][15:8], px[i][7:0], 1'b0, 1'b0, 1'b1, e, o);
      else       cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL gray_black[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      if (i >= 4) begin
        n_checks++;
        if (o !== want[i-4]) begin n_fail++; $display("FAIL gray_black_const[%0d]: got %s want %s", i-4, fmt(o), fmt(want[i-4])); end
      end
    end
  endtask

  task automatic test_mixed();
    logic [23:0] px [6];
    exp_t want [6];
    exp_t e, o;
    px = '{24'hC86432, 24'hFF0080, 24'h3264C8, 24'hFF0001, 24'h010000, 24'h000001};
    want = '{'{9'd20, 9'd192, 8'd200, 1'b0, 1'b0, 1'b1},
             '{9'd330, 9'd256, 8'd255, 1'b0, 1'b0, 1'b1},
             '{9'd220, 9'd192, 8'd200, 1'b0, 1'b0, 1'b1},
             '{9'd0, 9'd256, 8'd255, 1'b0, 1'b0, 1'b1},
             '{9'd0, 9'd256, 8'd1, 1'b0, 1'b0, 1'b1},
             '{9'd240, 9'd256, 8'd1, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) cycle(px[i][23:16], px[i][15:8], px[i][7:0], 1'b0, 1'b0, 1'b1, e, o);
      else       cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mixed[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      n_checks++;
      if (o.h >= 9'd360) begin n_fail++; $display("FAIL mixed_hrange: got h=%0d want <360", o.h); end
      if (i >= 4) begin
        n_checks++;
        if (o !== want[i-4]) begin n_fail++; $display("FAIL mixed_const[%0d]: got %s want %s", i-4, fmt(o), fmt(want[i-4])); end
      end
    end
  endtask

  task automatic test_syncs();
    exp_t e, o;
    logic [7:0] c;
    for (int i = 0; i < 12; i++) begin
      c = 8'(20 * i + 5);
      cycle(c, 8'd255 - c, 8'd60, i == 1, i == 3, i == 5, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL syncs[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      n_checks++;
      if ({o.vs, o.hs, o.de} !== {i == 5, i == 7, i == 9}) begin
        n_fail++;
        $display("FAIL sync_pulse[%0d]: got vs/hs/de=%b%b%b want %b%b%b", i, o.vs, o.hs, o.de, i == 5, i == 7, i == 9);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    logic [7:0] r, g, b;
    for (int i = 0; i < 64; i++) begin
      r = 8'($urandom_range(0, 255));
      g = ($urandom_range(0, 3) == 0) ? r : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? g : 8'($urandom_range(0, 255));
      cycle(r, g, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      n_checks++;
      if (o.h >= 9'd360) begin n_fail++; $display("FAIL b2b_hrange: got h=%0d want <360", o.h); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      cycle(8'(40 * i + 30), 8'(200 - 30 * i), 8'(17 * i), 1'b0, 1'b1, 1'b1, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mid_pre[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    #2 reset = 1'b1;
    #1;
    o = observed();
    n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL mid_assert: got %s want all zero", fmt(o)); end
    repeat (2) begin
      @(posedge clk); #1;
      o = observed();
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL mid_hold: got %s want all zero", fmt(o)); end
    end
    release_reset();
    for (int i = 5; i < 15; i++) begin
      if (i < 10) cycle(8'(20 * i), 8'(250 - 20 * i), 8'(9 * i), 1'b0, 1'b0, 1'b1, e, o);
      else        cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mid_post[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      if (i < 9) begin
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL mid_flush[%0d]: got %s want all zero", i, fmt(o)); end
      end
    end
  endtask

  task automatic test_de_gate();
    exp_t e, o, want;
`ifdef RGB2HSV_DE_GATE_EN
    want = '{9'd0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0};
`else
    want = '{9'd0, 9'd256, 8'd255, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      if (i == 0) cycle(8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, e, o);
      else        cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, e, o);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL de_gate[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      if (i == 4) begin
        n_checks++;
        if (o !== want) begin n_fail++; $display("FAIL de_gate_const: got %s want %s", fmt(o), fmt(want)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_primaries();
    test_gray_black();
    test_mixed();
    test_syncs();
    test_back_to_back();
    test_reset_mid();
    test_de_gate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
